// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Purpose:
//   Recovers 8-bit bytes from an asynchronous UART line (start bit, 8 data bits
//   LSB first, one stop bit). The line is brought into the clk domain through a
//   2-flop synchronizer. A falling edge on the synchronized line starts a frame.
//   The start bit is re-checked at mid-bit, and every data and stop bit is then
//   sampled one bit period later. Each byte lands in a one-entry holding
//   register with a valid/ready handshake. Framing and overrun events are
//   reported as single-cycle pulses.
//
// Parameters:
//   BAUD_RATE_NUMBER  clock cycles per bit period (>= 4)
//
// Ports:
//   clk          in   system clock, rising edge active
//   rst_n        in   asynchronous active-low reset
//   uart_rx      in   serial input, idle high, asynchronous to clk
//   rx_ready     in   consumer accepts rx_data when high together with rx_valid
//   rx_data      out  received byte, stable while rx_valid is high
//   rx_valid     out  holding register full
//   frame_error  out  one-cycle pulse: stop bit sampled low
//   rx_overrun   out  one-cycle pulse: frame finished while holding reg full
//   rx_busy      out  receiver is inside a frame (any state other than IDLE)
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int BAUD_RATE_NUMBER = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       rx_overrun,
  output logic       rx_busy
);

  // Width of the bit-period counter, which runs 0..BAUD_RATE_NUMBER-1.
  localparam int CW = (BAUD_RATE_NUMBER > 1) ? $clog2(BAUD_RATE_NUMBER) : 1;
  // Half a bit period, rounded down. Used to land on the middle of the start bit.
  localparam int HALF = BAUD_RATE_NUMBER / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_RATE_NUMBER - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_error_q, frame_error_d;
  logic            rx_overrun_q, rx_overrun_d;

  // Synchronizer chain plus a delayed copy of its output for edge detection.
  // All three flops reset high, which matches the idle line level. A reset
  // therefore never looks like a start edge.
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            s2_dly_q, s2_dly_d;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic            fall_edge;
  logic            cnt_last;
  logic            cnt_half;
  logic            last_bit;
  logic            can_load;

  assign fall_edge = s2_dly_q & ~s2_q;
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign cnt_half  = (cnt_q == CNT_HALF);
  assign last_bit  = (bidx_q == 3'd7);
  // The holding register accepts a new byte when it is empty, or when the
  // consumer takes the old byte on this same edge. In that case the load wins.
  assign can_load  = ~rx_valid_q | rx_ready;

  // ---------------------------------------------------------------------------
  // Process 1: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bidx_q        <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      s2_dly_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bidx_q        <= bidx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      rx_overrun_q  <= rx_overrun_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s2_dly_q      <= s2_dly_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Mid-bit re-check. A high line here means the edge was a glitch.
        if (cnt_half) begin
          state_d = s2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_last && last_bit) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit. A start edge right after the stop bit then
        // finds the receiver already in IDLE.
        if (cnt_last) begin
          state_d = s2_q ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        // A line stuck low must go high before another start edge can count.
        if (s2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: datapath and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_d          = uart_rx;
    s2_d          = s1_q;
    s2_dly_d      = s2_q;

    cnt_d         = cnt_q;
    bidx_d        = bidx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_error_d = 1'b0;
    rx_overrun_d  = 1'b0;

    // Consumer handshake. A load in the STOP branch below overrides this.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        bidx_d = '0;
      end
      ST_START: begin
        if (cnt_half) begin
          cnt_d  = '0;
          bidx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_last) begin
          cnt_d           = '0;
          shreg_d[bidx_q] = s2_q;
          // Wraps from 7 back to 0 as the FSM moves on to STOP.
          bidx_d          = bidx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!s2_q) begin
            frame_error_d = 1'b1;
          end else if (can_load) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end else begin
            // The older unread byte is kept. The new one is dropped.
            rx_overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d  = '0;
        bidx_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign rx_overrun  = rx_overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule
